alu_muldiv_ctrl: RTL
====================

# alu_muldiv_ctrl

Parametrised successor to the single-cycle ALU decoder in the multicycle RISC-V core.
- Combinationally decodes ALU_Op/Funct3/Funct7 into a 4-bit ALUControl covering all of RV32I.
- Flags RV32M instructions and executes them in an iterative multiply/divide engine with a start/busy/done handshake.
- Sits beside the main ALU. The multicycle control FSM stalls on busy and writes Result back on done.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be ≥ 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ALU_Op  input  2  00 load/store, 01 branch, 10 R/I-type, 11 reserved.
- Funct3  input  3  instruction funct3.
- Funct7  input  7  instruction funct7.
- start  input  1  request; the engine acts only when is_muldiv=1 and state is IDLE.
- SrcA  input  XLEN  operand A (rs1), sampled with start.
- SrcB  input  XLEN  operand B (rs2), sampled with start.
- ALUControl  output  4  combinational decode for the main ALU.
- is_muldiv  output  1  combinational; 1 when ALU_Op=10 and Funct7=0000001.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when Result is valid.
- Result  output  XLEN  registered M-extension result; held until the next accepted start.

## Operation
ALUControl decode (combinational):
- ALU_Op 00 → 0000 (add).
- ALU_Op 01 → 0001 (sub).
- ALU_Op 11 → 0000.
- ALU_Op 10, Funct3 000 → add 0000; sub 0001 when Funct7=0100000.
- ALU_Op 10, Funct3 001 → sll 0101.
- ALU_Op 10, Funct3 010 → slt 0111.
- ALU_Op 10, Funct3 011 → sltu 1001.
- ALU_Op 10, Funct3 100 → xor 0010.
- ALU_Op 10, Funct3 101 → srl 0110; sra 1000 when Funct7=0100000.
- ALU_Op 10, Funct3 110 → or 0100.
- ALU_Op 10, Funct3 111 → and 0011.
- is_muldiv=1 → 1111, which overrides the Funct3 decode.
- Codes 0000/0001/0011/0100/0111 keep their legacy meanings.

M-op selection (Funct3, latched at start):
- 000 MUL: low XLEN bits of the product.
- 001 MULH: high bits, signed×signed.
- 010 MULHSU: high bits, signed×unsigned.
- 011 MULHU: high bits, unsigned×unsigned.
- 100 DIV, 101 DIVU: quotient.
- 110 REM, 111 REMU: remainder.

Engine FSM (states IDLE, CALC, DONE):
- IDLE→CALC on start & is_muldiv. Latch op, operand magnitudes, result-sign flags, and set count=0.
- IDLE→DONE directly on the two division special cases:
  - Divide by zero (SrcB=0): quotient = all ones; remainder = SrcA.
  - Signed overflow (DIV/REM with SrcA=100…0, SrcB=all ones): quotient = SrcA; remainder = 0.
- CALC performs one iteration per cycle:
  - Multiply: shift-add on a 2·XLEN accumulator.
  - Divide: restoring shift-subtract.
- CALC→DONE on the iteration where count=XLEN-1. Sign correction (two's-complement negate) is applied on that same edge.
- DONE→IDLE unconditionally. done=1 only in DONE.

Arithmetic rules:
- Signed operands are converted to magnitude.
- Product is negated when the operand signs differ.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.

Boundary conditions:
- start while busy: ignored; no queuing.
- start with is_muldiv=0: ignored by the engine; only the combinational decode applies.
- Decode inputs may change during CALC without affecting the running op.
- rst_n low at any time, including mid-CALC: immediately IDLE, busy=0, done=0, Result=0, count=0; the in-flight op is discarded.

## Timing
- Reset values: busy=0, done=0, Result=0.
- ALUControl and is_muldiv are combinational from the inputs.
- Start accepted on edge E:
  - busy=1 from E.
  - Normal ops: done=1 for the single cycle following edge E+XLEN; busy falls at E+XLEN+1. A new start can be accepted at E+XLEN+1.
  - Special cases: done=1 in the cycle following edge E; busy falls at E+1.
- Result updates on the edge entering DONE and is stable while done=1 and afterwards.

## Test plan
- Decode sweep:
  - ALU_Op=10, Funct3=101, Funct7=0100000 → ALUControl=1000, is_muldiv=0.
  - ALU_Op=01 → 0001.
  - Funct7=0000001 → 1111, is_muldiv=1.
- MUL signed: Funct3=000, SrcA=0xFFFFFFFD (−3), SrcB=7 → Result=0xFFFFFFEB; done exactly 32 cycles after the start edge; one-cycle pulse.
- MULHU: SrcA=SrcB=0xFFFFFFFF → Result=0xFFFFFFFE. Same operands with MULH → 0x00000000.
- DIV/REM signed: SrcA=−7, SrcB=2 → DIV 0xFFFFFFFD (−3); REM 0xFFFFFFFF (−1).
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - All three: done in the cycle after start.
- Handshake/reset:
  - start re-asserted mid-CALC → no effect on the running op.
  - rst_n pulsed low at iteration 10 → busy=0, Result=0 immediately.
  - Next start → correct result with full latency.

Source files
------------

// File: rtl/alu_muldiv_ctrl_if.sv
// rtl/alu_muldiv_ctrl_if.sv - decode inputs, start/busy/done handshake and M-extension operands/result
interface alu_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALU_Op;
    logic [2:0]      Funct3;
    logic [6:0]      Funct7;
    logic            start;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [3:0]      ALUControl;
    logic            is_muldiv;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output ALU_Op, Funct3, Funct7, start, SrcA, SrcB,
        input  ALUControl, is_muldiv, busy, done, Result
    );

    modport slave (
        input  ALU_Op, Funct3, Funct7, start, SrcA, SrcB,
        output ALUControl, is_muldiv, busy, done, Result
    );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - RV32I ALU decode plus iterative RV32M multiply/divide engine
module alu_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_muldiv_ctrl_if.slave  bus
);
    localparam logic [6:0]       F7_ALT    = 7'b0100000;
    localparam logic [6:0]       F7_MULDIV = 7'b0000001;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        op;
    logic [XLEN-1:0]   a_mag, b_mag, result;
    logic [2*XLEN-1:0] acc;
    logic              neg_res;
    logic [CNT_W-1:0]  count;
    logic              accept, special;
    logic [3:0]        alu_control;

    assign bus.is_muldiv  = (bus.ALU_Op == 2'b10) && (bus.Funct7 == F7_MULDIV);
    assign bus.ALUControl = alu_control;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.Result     = result;

    always_comb begin
        alu_control = 4'b0000;
        if (bus.ALU_Op == 2'b01) begin
            alu_control = 4'b0001;
        end else if (bus.ALU_Op == 2'b10) begin
            if (bus.is_muldiv) begin
                alu_control = 4'b1111;
            end else begin
                case (bus.Funct3)
                    3'b000:  alu_control = (bus.Funct7 == F7_ALT) ? 4'b0001 : 4'b0000;
                    3'b001:  alu_control = 4'b0101;
                    3'b010:  alu_control = 4'b0111;
                    3'b011:  alu_control = 4'b1001;
                    3'b100:  alu_control = 4'b0010;
                    3'b101:  alu_control = (bus.Funct7 == F7_ALT) ? 4'b1000 : 4'b0110;
                    3'b110:  alu_control = 4'b0100;
                    default: alu_control = 4'b0011;
                endcase
            end
        end
    end

    // Operand conditioning at start: which operands are signed, their magnitudes and the result sign.
    logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        a_signed_in = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                      (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
        b_signed_in = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
        a_neg_in    = a_signed_in && bus.SrcA[XLEN-1];
        b_neg_in    = b_signed_in && bus.SrcB[XLEN-1];
        a_mag_in    = a_neg_in ? -bus.SrcA : bus.SrcA;
        b_mag_in    = b_neg_in ? -bus.SrcB : bus.SrcB;
        neg_in      = (bus.Funct3[2:1] == 2'b11) ? a_neg_in : (a_neg_in ^ b_neg_in);
        div_zero    = bus.Funct3[2] && (bus.SrcB == '0);
        div_ovf     = ((bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110)) &&
                      (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.SrcB);
        if (div_zero)
            special_res = bus.Funct3[1] ? bus.SrcA : '1;
        else
            special_res = bus.Funct3[1] ? '0 : bus.SrcA;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step on acc = {hi, lo}.
    logic [XLEN:0]     mul_sum, rem_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = rem_shift - {1'b0, b_mag};
        if (!op[2])
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        prod_fix = neg_res ? -acc_next : acc_next;
        quo_fix  = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = neg_res ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op)
            3'b000:         final_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: final_res = quo_fix;
            3'b110, 3'b111: final_res = rem_fix;
            default:        final_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        special    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.is_muldiv) begin
                    accept     = 1'b1;
                    special    = div_zero || div_ovf;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            count   <= '0;
            result  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op      <= bus.Funct3;
                a_mag   <= a_mag_in;
                b_mag   <= b_mag_in;
                neg_res <= neg_in;
                count   <= '0;
                acc     <= {{XLEN{1'b0}}, (bus.Funct3[2] ? a_mag_in : b_mag_in)};
                if (special) result <= special_res;
            end else if (state == CALC) begin
                acc   <= acc_next;
                count <= count + CNT_W'(1);
                if (count == LAST) result <= final_res;
            end
        end
    end
endmodule
